crypto_feeder: RTL and testbench
================================

CRYPTO_FEEDER -- requirements
Module: crypto_feeder

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have: start  in  1  begin a message; sampled only in IDLE.
REQ-004 SHALL have: key_in  in  10  SDES key, latched on accepted start.
REQ-005 SHALL have: mode_in  in  1  0 = encrypt, 1 = decrypt; latched on accepted start.
REQ-006 SHALL have: msg_len  in  8  message length in bytes, 1..255; latched on accepted start.
REQ-007 SHALL have: byte_in  in  8  message byte; byte_valid  in  1  byte present; byte_ready  out  1  byte accepted when valid&ready.
REQ-008 SHALL have: data_out  out  10+8 split as key_out  out  10, mode_out  out  1, data_out  out  8, all driving the crypto datapath.
REQ-009 SHALL have: feed_valid  out  1  data_out holds a new byte this cycle; hash_clr  out  1  one-cycle hash clear pulse.
REQ-010 SHALL have: hash_in  in  32  final hash from the crypto datapath; hash_result  out  32  captured hash.
REQ-011 SHALL have: busy  out  1; done  out  1  one-cycle completion pulse; byte_count  out  8  bytes fed so far.

Function
REQ-012 SHALL contain a 4-entry x 8-bit byte FIFO with separate accepted-byte and fed-byte counters.
REQ-013 SHALL implement states IDLE, CLEAR, FEED, SETTLE, DONE.
REQ-014 IDLE: start=1 with msg_len != 0 SHALL latch key/mode/len, clear both counters, go CLEAR; start with msg_len = 0 SHALL be ignored.
REQ-015 CLEAR SHALL last exactly one cycle with hash_clr=1, then go FEED.
REQ-016 byte_ready SHALL be 1 only in CLEAR or FEED, FIFO not full, and accepted count < latched len; registered-free, combinational from state/flags.
REQ-017 FEED: each cycle the FIFO is non-empty SHALL pop one byte, register it onto data_out with feed_valid=1 the next cycle, and increment byte_count.
REQ-018 Push and pop in the same cycle SHALL both occur; FIFO occupancy unchanged.
REQ-019 When byte_count reaches latched len, SHALL go SETTLE; no further pops.
REQ-020 SETTLE SHALL last exactly 2 cycles, then capture hash_in into hash_result and go DONE.
REQ-021 DONE SHALL assert done=1 for one cycle, then go IDLE; hash_result SHALL hold until the next capture or reset.
REQ-022 feed_valid=0 cycles SHALL keep data_out at its previous value.
REQ-023 key_out/mode_out SHALL hold latched values from accepted start until the next accepted start.
REQ-024 busy SHALL be 1 in CLEAR, FEED, SETTLE, DONE; start while busy SHALL be ignored.
REQ-025 FIFO pointers SHALL wrap modulo 4; full = 4 entries, empty = 0.
REQ-026 Bytes offered after accepted count reaches len SHALL not be accepted (byte_ready=0).

Reset
REQ-027 reset SHALL force IDLE, empty FIFO, zero counters, and outputs: byte_ready=0, data_out=0, key_out=0, mode_out=0, feed_valid=0, hash_clr=0, hash_result=0, busy=0, done=0, byte_count=0.
REQ-028 reset asserted mid-message SHALL abort with no done pulse; reset has priority over all other inputs.

Verification
REQ-029 reset, start, key_in=10'h282, mode_in=0, msg_len=3, bytes 8'hA5,8'h3C,8'hFF back-to-back -> hash_clr one cycle, feed_valid 3 cycles with data_out A5,3C,FF, done 2 cycles after last feed+1, byte_count=3, hash_result = hash_in sampled that cycle.
REQ-030 msg_len=6, byte_valid held high, no pops stalled by upstream -> FIFO never exceeds 4, byte_ready drops only when accepted count=6.
REQ-031 start with msg_len=0 -> stays IDLE, busy=0, no hash_clr.
REQ-032 start pulsed during FEED with different key_in -> ignored, key_out unchanged.
REQ-033 reset after 2 of 5 bytes fed -> all outputs at reset values next cycle, no done; fresh start then completes normally.
REQ-034 byte_valid toggling 1/0 with msg_len=4 -> feed_valid gaps match input gaps, data order preserved, done once.

Source files
------------

// File: rtl/crypto_feeder.sv
// crypto_feeder
// Front-end sequencer for an SDES/hash datapath. It accepts a message
// description on start, buffers incoming bytes in a 4-deep FIFO and feeds
// them one per cycle to the datapath. It then lets the hash settle for two
// cycles, captures the final hash and pulses done.
//
// Ports
//   clk          single clock, rising edge
//   reset        synchronous, active-high
//   start        begin a message (sampled only in IDLE)
//   key_in       10-bit SDES key, latched on accepted start
//   mode_in      0 = encrypt, 1 = decrypt, latched on accepted start
//   msg_len      message length in bytes (1..255), latched on accepted start
//   byte_in      upstream message byte
//   byte_valid   upstream byte present
//   byte_ready   byte accepted when byte_valid & byte_ready (combinational)
//   key_out      latched key to the datapath
//   mode_out     latched mode to the datapath
//   data_out     byte to the datapath, holds when feed_valid = 0
//   feed_valid   data_out carries a new byte this cycle
//   hash_clr     one-cycle hash clear pulse at message start
//   hash_in      final hash from the datapath
//   hash_result  captured hash, held until next capture or reset
//   busy         message in progress
//   done         one-cycle completion pulse
//   byte_count   bytes fed so far
module crypto_feeder (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [9:0]  key_in,
    input  logic        mode_in,
    input  logic [7:0]  msg_len,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [9:0]  key_out,
    output logic        mode_out,
    output logic [7:0]  data_out,
    output logic        feed_valid,
    output logic        hash_clr,
    input  logic [31:0] hash_in,
    output logic [31:0] hash_result,
    output logic        busy,
    output logic        done,
    output logic [7:0]  byte_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        FEED   = 3'd2,
        SETTLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t      state_reg;
    logic [7:0]  fifo_mem [0:3];
    logic [1:0]  wr_ptr_reg;
    logic [1:0]  rd_ptr_reg;
    logic [2:0]  fill_reg;
    logic [7:0]  len_reg;
    logic [7:0]  acc_cnt_reg;
    logic        settle_cnt_reg;

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;

    assign fifo_full  = (fill_reg == 3'd4);
    assign fifo_empty = (fill_reg == 3'd0);

    // Upstream may start filling the FIFO during the CLEAR cycle; the
    // accepted-byte limit stops any byte beyond the latched length.
    assign byte_ready = ((state_reg == CLEAR) || (state_reg == FEED))
                        && !fifo_full && (acc_cnt_reg < len_reg);
    assign push       = byte_valid && byte_ready;
    assign pop        = (state_reg == FEED) && !fifo_empty
                        && (byte_count != len_reg);

    // Storage array without reset so it maps onto distributed/block RAM;
    // the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= byte_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            wr_ptr_reg     <= 2'd0;
            rd_ptr_reg     <= 2'd0;
            fill_reg       <= 3'd0;
            len_reg        <= 8'd0;
            acc_cnt_reg    <= 8'd0;
            settle_cnt_reg <= 1'b0;
            key_out        <= 10'd0;
            mode_out       <= 1'b0;
            data_out       <= 8'd0;
            feed_valid     <= 1'b0;
            hash_clr       <= 1'b0;
            hash_result    <= 32'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
            byte_count     <= 8'd0;
        end else begin
            hash_clr   <= 1'b0;
            done       <= 1'b0;
            feed_valid <= 1'b0;

            if (push) begin
                wr_ptr_reg  <= wr_ptr_reg + 2'd1;
                acc_cnt_reg <= acc_cnt_reg + 8'd1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 2'd1;
                data_out   <= fifo_mem[rd_ptr_reg];
                feed_valid <= 1'b1;
                byte_count <= byte_count + 8'd1;
            end
            // Simultaneous push and pop leave occupancy unchanged.
            fill_reg <= fill_reg + {2'd0, push} - {2'd0, pop};

            case (state_reg)
                IDLE: begin
                    if (start && (msg_len != 8'd0)) begin
                        key_out     <= key_in;
                        mode_out    <= mode_in;
                        len_reg     <= msg_len;
                        acc_cnt_reg <= 8'd0;
                        byte_count  <= 8'd0;
                        wr_ptr_reg  <= 2'd0;
                        rd_ptr_reg  <= 2'd0;
                        fill_reg    <= 3'd0;
                        hash_clr    <= 1'b1;
                        busy        <= 1'b1;
                        state_reg   <= CLEAR;
                    end
                end
                CLEAR: begin
                    state_reg <= FEED;
                end
                FEED: begin
                    if (pop && ((byte_count + 8'd1) == len_reg)) begin
                        settle_cnt_reg <= 1'b0;
                        state_reg      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt_reg) begin
                        hash_result <= hash_in;
                        done        <= 1'b1;
                        state_reg   <= DONE;
                    end else begin
                        settle_cnt_reg <= 1'b1;
                    end
                end
                DONE: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crypto_feeder.sv
module tb_crypto_feeder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  key_in;
    logic        mode_in;
    logic [7:0]  msg_len;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [9:0]  key_out;
    logic        mode_out;
    logic [7:0]  data_out;
    logic        feed_valid;
    logic        hash_clr;
    logic [31:0] hash_in;
    logic [31:0] hash_result;
    logic        busy;
    logic        done;
    logic [7:0]  byte_count;

    crypto_feeder dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .key_in     (key_in),
        .mode_in    (mode_in),
        .msg_len    (msg_len),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .key_out    (key_out),
        .mode_out   (mode_out),
        .data_out   (data_out),
        .feed_valid (feed_valid),
        .hash_clr   (hash_clr),
        .hash_in    (hash_in),
        .hash_result(hash_result),
        .busy       (busy),
        .done       (done),
        .byte_count (byte_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;

    logic [7:0] data_q [$];
    logic [7:0] done_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Free-running hash source so the capture cycle is observable.
    initial begin
        hash_in = 32'h1000_0001;
        forever begin
            @(posedge clk);
            #1 hash_in = hash_in + 32'h1357_9BDF;
        end
    end

    // Monitor / scoreboard
    initial begin
        int          cyc = 0;
        int          last_feed_cyc = 0;
        int          feeds = 0;
        logic [31:0] prev_hash = 32'd0;
        logic [7:0]  last_data = 8'd0;
        logic        prev_done = 1'b0;
        logic        prev_clr = 1'b0;
        logic [7:0]  exp_b;
        forever begin
            @(negedge clk);
            cyc++;
            if (feed_valid) begin
                if (data_q.size() == 0) begin
                    check("feed_unexpected", {24'd0, data_out}, 32'hFFFF_FFFF);
                end else begin
                    exp_b = data_q.pop_front();
                    check("feed_data", {24'd0, data_out}, {24'd0, exp_b});
                    $display("feed byte %02h (expected %02h)", data_out, exp_b);
                end
                last_data = data_out;
                last_feed_cyc = cyc;
                feeds++;
            end else if (reset) begin
                last_data = 8'd0;
            end else if (busy) begin
                check("data_hold", {24'd0, data_out}, {24'd0, last_data});
            end
            if (hash_clr) begin
                check("hash_clr_single", {31'd0, prev_clr}, 32'd0);
                feeds = 0;
            end
            if (done) begin
                check("done_single", {31'd0, prev_done}, 32'd0);
                if (done_q.size() == 0) begin
                    check("done_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_b = done_q.pop_front();
                    check("done_byte_count", {24'd0, byte_count}, {24'd0, exp_b});
                    check("done_feed_total", feeds, {24'd0, exp_b});
                    check("done_latency", cyc - last_feed_cyc, 32'd2);
                    check("done_hash", hash_result, prev_hash);
                    $display("done count %0d hash %08h", byte_count, hash_result);
                end
                n_done++;
            end
            prev_done = done;
            prev_clr  = hash_clr;
            prev_hash = hash_in;
        end
    end

    task automatic check_reset_outputs();
        check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
        check("rst_data_out", {24'd0, data_out}, 32'd0);
        check("rst_key_mode", {21'd0, key_out, mode_out}, 32'd0);
        check("rst_feed_clr", {30'd0, feed_valid, hash_clr}, 32'd0);
        check("rst_hash_result", hash_result, 32'd0);
        check("rst_busy_done", {30'd0, busy, done}, 32'd0);
        check("rst_byte_count", {24'd0, byte_count}, 32'd0);
    endtask

    // gap_mode 0: back-to-back bytes; 1: byte_valid toggles 1/0.
    // inj: pulse start with another key while feeding.
    // abort_at: nonzero -> reset once byte_count reaches this value.
    task automatic run_msg(input logic [9:0] k, input logic m, input logic [7:0] len,
                           input logic [63:0] b, input int gap_mode, input bit inj,
                           input int abort_at);
        int   idx = 0;
        int   t = 0;
        int   d0;
        bit   acc;
        bit   injected = 0;
        d0 = n_done;
        key_in = k; mode_in = m; msg_len = len; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        done_q.push_back(len);
        byte_in = b[7:0];
        byte_valid = (gap_mode == 0) || (t % 2 == 0);
        @(negedge clk);
        check("clr_pulse", {31'd0, hash_clr}, 32'd1);
        check("start_busy", {31'd0, busy}, 32'd1);
        check("latched_key_mode", {21'd0, key_out, mode_out}, {21'd0, k, m});
        while (idx < len && t < 200) begin
            if (t > 0) @(negedge clk);
            if (gap_mode == 0) check("ready_stream", {31'd0, byte_ready}, 32'd1);
            acc = byte_valid && byte_ready;
            if (abort_at != 0 && byte_count == abort_at[7:0]) begin
                byte_valid = 1'b0;
                @(posedge clk);
                #1 reset = 1'b1;
                @(posedge clk);
                #1 data_q.delete();
                done_q.delete();
                @(negedge clk);
                check_reset_outputs();
                check("abort_no_done", n_done, d0);
                @(posedge clk);
                #1 reset = 1'b0;
                $display("reset abort after %0d bytes fed", abort_at);
                return;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                data_q.push_back(b[idx*8 +: 8]);
                idx++;
            end
            t++;
            if (inj && !injected && idx == 1) begin
                start = 1'b1; key_in = ~k; injected = 1;
            end else begin
                start = 1'b0; key_in = k;
            end
            byte_in = b[idx*8 +: 8];
            byte_valid = (gap_mode == 0) || (t % 2 == 0);
        end
        start = 1'b0; key_in = k;
        if (t >= 200) check("accept_timeout", 32'd1, 32'd0);
        // Offer one more byte beyond the length: must be refused.
        byte_in = 8'hEE; byte_valid = 1'b1;
        @(negedge clk);
        check("ready_after_len", {31'd0, byte_ready}, 32'd0);
        @(posedge clk);
        #1 byte_valid = 1'b0;
        t = 0;
        while (n_done == d0 && t < 40) begin
            @(posedge clk);
            #1 t++;
        end
        if (n_done == d0) check("done_timeout", 32'd1, 32'd0);
        check("key_held", {22'd0, key_out}, {22'd0, k});
        @(negedge clk);
        check("idle_after_done", {31'd0, busy}, 32'd0);
        check("single_done", n_done - d0, 32'd1);
        $display("message len %0d key %03h mode %0d complete", len, k, m);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; key_in = 10'd0; mode_in = 1'b0;
        msg_len = 8'd0; byte_in = 8'd0; byte_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1 reset = 1'b0;

        // Basic three-byte message.
        run_msg(10'h282, 1'b0, 8'd3, 64'h0000_0000_00FF_3CA5, 0, 0, 0);

        // Six bytes with byte_valid held high.
        run_msg(10'h155, 1'b1, 8'd6, 64'h0000_6655_4433_2211, 0, 0, 0);

        // Zero-length start is ignored.
        msg_len = 8'd0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("len0_busy", {31'd0, busy}, 32'd0);
            check("len0_clr", {31'd0, hash_clr}, 32'd0);
        end
        $display("zero-length start ignored");

        // Start pulsed during FEED with a different key.
        run_msg(10'h0F3, 1'b0, 8'd4, 64'h0000_0000_DEAD_BEEF, 0, 1, 0);

        // Reset after two of five bytes fed, then a fresh message.
        run_msg(10'h3A1, 1'b1, 8'd5, 64'h0000_0055_4433_2211, 0, 0, 2);
        run_msg(10'h111, 1'b0, 8'd2, 64'h0000_0000_0000_7E81, 0, 0, 0);

        // Toggling byte_valid.
        run_msg(10'h2C4, 1'b1, 8'd4, 64'h0000_0000_0C0B_0A09, 1, 0, 0);

        repeat (3) @(posedge clk);
        check("no_leftover_feeds", data_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
